// File: rtl/rotate_right_serial_if.sv
// Request/response handshake bundle for rotate_right_serial.
// slave is the rotator side, master is the requester/consumer side.
interface rotate_right_serial_if;
    logic [31:0] operand_i;
    logic [4:0]  ror_amount_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] result_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;

    modport slave (
        input  operand_i,
        input  ror_amount_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output result_o,
        output valid_o,
        output busy_o
    );

    modport master (
        output operand_i,
        output ror_amount_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  result_o,
        input  valid_o,
        input  busy_o
    );
endinterface

// File: rtl/rotate_right_serial.sv
// Sequential 32-bit rotate-right: byte steps first, then bit steps, one step per cycle.
// Build option ROTR_FAST_BIT_EN: the bit phase finishes in one cycle via a 3-level mux.
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// BYTE  | rotating right by 8 per cycle while byte_cnt != 0
// BIT   | rotating right by the remaining bit count
// DONE  | result_o valid, held until ready_i
module rotate_right_serial (
    input logic                  clk_i,
    input logic                  rst_n_i,
    rotate_right_serial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        BIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] work, work_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;

`ifdef ROTR_FAST_BIT_EN
    logic [31:0] rot_s1, rot_s2, rot_s3;

    always_comb begin
        rot_s1 = bit_cnt[0] ? {work[0],     work[31:1]}   : work;
        rot_s2 = bit_cnt[1] ? {rot_s1[1:0], rot_s1[31:2]} : rot_s1;
        rot_s3 = bit_cnt[2] ? {rot_s2[3:0], rot_s2[31:4]} : rot_s2;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            work     <= 32'h0;
            byte_cnt <= 2'd0;
            bit_cnt  <= 3'd0;
        end else begin
            state    <= state_nxt;
            work     <= work_nxt;
            byte_cnt <= byte_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        work_nxt     = work;
        byte_cnt_nxt = byte_cnt;
        bit_cnt_nxt  = bit_cnt;
        case (state)
            IDLE: begin
                if (bus.valid_i) begin
                    work_nxt     = bus.operand_i;
                    byte_cnt_nxt = bus.ror_amount_i[4:3];
                    bit_cnt_nxt  = bus.ror_amount_i[2:0];
                    if (bus.ror_amount_i[4:3] != 2'd0)
                        state_nxt = BYTE;
                    else if (bus.ror_amount_i[2:0] != 3'd0)
                        state_nxt = BIT;
                    else
                        state_nxt = DONE;
                end
            end
            BYTE: begin
                work_nxt     = {work[7:0], work[31:8]};
                byte_cnt_nxt = byte_cnt - 2'd1;
                if (byte_cnt == 2'd1)
                    state_nxt = (bit_cnt != 3'd0) ? BIT : DONE;
            end
            BIT: begin
`ifdef ROTR_FAST_BIT_EN
                work_nxt    = rot_s3;
                bit_cnt_nxt = 3'd0;
                state_nxt   = DONE;
`else
                work_nxt    = {work[0], work[31:1]};
                bit_cnt_nxt = bit_cnt - 3'd1;
                if (bit_cnt == 3'd1)
                    state_nxt = DONE;
`endif
            end
            DONE: begin
                // Return through IDLE so no request is taken on the output handshake edge.
                if (bus.ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.busy_o   = (state != IDLE);
    assign bus.result_o = work;

endmodule
